mem_port_arbiter: RTL and testbench

//  Parametrised N-channel front end to the single Memory handshake port (Addr/Length/Rd/Wr/Enable/Rdy).

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_picker.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and channel index width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

  // Width of a channel index; never narrower than one bit so N_CH == 1 still builds.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select over the request vector.
// ARB_ROUND_ROBIN_EN: rotate from last granted + 1; otherwise a plain lowest-index priority encoder.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CH_IDX_W = ch_idx_w(N_CH)
) (
  input  logic [N_CH-1:0]     req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [CH_IDX_W-1:0] last_idx_i,
  output logic [CH_IDX_W-1:0] grant_idx_o,
`endif
  output logic [N_CH-1:0]     grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic                found;
  logic [CH_IDX_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = CH_IDX_W'((32'(last_idx_i) + k) % N_CH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        grant_o     = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o = cand;
      end
    end
  end
`else
  always_comb begin
    grant_o = '0;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel front end sharing one Memory handshake port; one access in flight at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_CH*ADDR_W-1:0]   ChAddr,
  input  logic [N_CH*DATA_W-1:0]   ChWrData,
  input  logic [N_CH-1:0]          ChLength,
  input  logic [N_CH-1:0]          ChRd,
  input  logic [N_CH-1:0]          ChWr,
  input  logic [N_CH-1:0]          ChEnable,
  output logic [N_CH-1:0]          ChRdy,
  output logic [DATA_W-1:0]        ChRdData,
  output logic [N_CH-1:0]          ChGrant,
  output logic [ADDR_W-1:0]        MemAddr,
  output logic                     MemLength,
  output logic                     MemRd,
  output logic                     MemWr,
  output logic                     MemEnable,
  output logic [DATA_W-1:0]        toMemData,
  input  logic                     MemRdy,
  input  logic [DATA_W-1:0]        fromMemData
);

  localparam int unsigned CH_IDX_W = ch_idx_w(N_CH);

  arb_state_e          state_q;
  logic [N_CH-1:0]     pick_grant;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_len;
  logic                win_rd;
  logic                win_wr;

`ifdef ARB_ROUND_ROBIN_EN
  // Starts at the last channel so channel 0 wins the first arbitration after reset.
  localparam logic [CH_IDX_W-1:0] LastInit = CH_IDX_W'(N_CH - 1);
  logic [CH_IDX_W-1:0] last_q;
  logic [CH_IDX_W-1:0] pick_idx;
`endif

  mem_arb_picker #(
    .N_CH     (N_CH),
    .CH_IDX_W (CH_IDX_W)
  ) u_picker (
    .req_i       (ChEnable),
`ifdef ARB_ROUND_ROBIN_EN
    .last_idx_i  (last_q),
    .grant_idx_o (pick_idx),
`endif
    .grant_o     (pick_grant)
  );

  // One-hot mux of the winning channel's request fields.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_len   = 1'b0;
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_grant[i]) begin
        win_addr  = ChAddr[i*ADDR_W +: ADDR_W];
        win_wdata = ChWrData[i*DATA_W +: DATA_W];
        win_len   = ChLength[i];
        win_rd    = ChRd[i];
        win_wr    = ChWr[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ChRdy     <= '0;
      ChRdData  <= '0;
      ChGrant   <= '0;
      MemAddr   <= '0;
      MemLength <= 1'b0;
      MemRd     <= 1'b0;
      MemWr     <= 1'b0;
      MemEnable <= 1'b0;
      toMemData <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= LastInit;
`endif
    end else begin
      ChRdy <= '0;
      unique case (state_q)
        IDLE: begin
          if (|ChEnable) begin
            ChGrant   <= pick_grant;
            MemAddr   <= win_addr;
            toMemData <= win_wdata;
            MemLength <= win_len;
            MemRd     <= win_rd;
            // Read wins when a requester raises both strobes.
            MemWr     <= win_wr & ~win_rd;
            MemEnable <= 1'b1;
            state_q   <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= pick_idx;
`endif
          end
        end
        BUSY: begin
          if (MemRdy) begin
            if (MemRd) begin
              ChRdData <= fromMemData;
            end
            ChRdy     <= ChGrant;
            ChGrant   <= '0;
            MemAddr   <= '0;
            MemLength <= 1'b0;
            MemRd     <= 1'b0;
            MemWr     <= 1'b0;
            MemEnable <= 1'b0;
            toMemData <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (N_CH=2): directed cases plus randomized traffic
// compared every cycle against a transaction-level model. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 24;
  localparam int DW  = 32;

  logic              Clk;
  logic              Reset;
  logic [NCH*AW-1:0] ChAddr;
  logic [NCH*DW-1:0] ChWrData;
  logic [NCH-1:0]    ChLength, ChRd, ChWr, ChEnable;
  logic [NCH-1:0]    ChRdy, ChGrant;
  logic [DW-1:0]     ChRdData, toMemData, fromMemData;
  logic [AW-1:0]     MemAddr;
  logic              MemLength, MemRd, MemWr, MemEnable, MemRdy;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .N_CH   (NCH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ChAddr      (ChAddr),
    .ChWrData    (ChWrData),
    .ChLength    (ChLength),
    .ChRd        (ChRd),
    .ChWr        (ChWr),
    .ChEnable    (ChEnable),
    .ChRdy       (ChRdy),
    .ChRdData    (ChRdData),
    .ChGrant     (ChGrant),
    .MemAddr     (MemAddr),
    .MemLength   (MemLength),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .MemEnable   (MemEnable),
    .toMemData   (toMemData),
    .MemRdy      (MemRdy),
    .fromMemData (fromMemData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  // ---------------- reference model ----------------
  // Transaction view: phase 0 = no access, 1 = access on the memory port, 2 = completion pulse.
  int             m_phase = 0;
  int             m_owner = 0;
  int             m_last  = NCH - 1;
  logic [NCH-1:0] e_grant = '0, e_rdy = '0;
  logic [DW-1:0]  e_rddata = '0, e_tomem = '0;
  logic [AW-1:0]  e_maddr = '0;
  logic           e_mlen = 1'b0, e_mrd = 1'b0, e_mwr = 1'b0, e_men = 1'b0;

  function automatic int pick(input logic [NCH-1:0] req, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (last + k) % NCH;
      if (req[c]) return c;
    end
`else
    for (int k = 0; k < NCH; k++) begin
      if (req[k]) return k;
    end
`endif
    return 0;
  endfunction

  function automatic logic [NCH-1:0] onehot(input int w);
    logic [NCH-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge Clk) begin : model
    int w;
    w = 0;
    if (Reset) begin
      m_phase  <= 0;
      m_last   <= NCH - 1;
      e_grant  <= '0;
      e_rdy    <= '0;
      e_rddata <= '0;
      e_tomem  <= '0;
      e_maddr  <= '0;
      e_mlen   <= 1'b0;
      e_mrd    <= 1'b0;
      e_mwr    <= 1'b0;
      e_men    <= 1'b0;
    end else if (m_phase == 0) begin
      e_rdy <= '0;
      if (ChEnable != '0) begin
        w = pick(ChEnable, m_last);
        m_last  <= w;
        m_owner <= w;
        e_grant <= onehot(w);
        e_maddr <= ChAddr[w*AW +: AW];
        e_tomem <= ChWrData[w*DW +: DW];
        e_mlen  <= ChLength[w];
        e_mrd   <= ChRd[w];
        e_mwr   <= ChWr[w] && !ChRd[w];
        e_men   <= 1'b1;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (MemRdy) begin
        if (e_mrd) e_rddata <= fromMemData;
        e_rdy   <= onehot(m_owner);
        e_grant <= '0;
        e_maddr <= '0;
        e_tomem <= '0;
        e_mlen  <= 1'b0;
        e_mrd   <= 1'b0;
        e_mwr   <= 1'b0;
        e_men   <= 1'b0;
        m_phase <= 2;
      end
    end else begin
      e_rdy   <= '0;
      m_phase <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    chk("ChGrant", 64'(ChGrant), 64'(e_grant));
    chk("ChRdy", 64'(ChRdy), 64'(e_rdy));
    chk("ChRdData", 64'(ChRdData), 64'(e_rddata));
    chk("MemAddr", 64'(MemAddr), 64'(e_maddr));
    chk("toMemData", 64'(toMemData), 64'(e_tomem));
    chk("MemLength", 64'(MemLength), 64'(e_mlen));
    chk("MemRd", 64'(MemRd), 64'(e_mrd));
    chk("MemWr", 64'(MemWr), 64'(e_mwr));
    chk("MemEnable", 64'(MemEnable), 64'(e_men));
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    ChAddr      = '0;
    ChWrData    = '0;
    ChLength    = '0;
    ChRd        = '0;
    ChWr        = '0;
    ChEnable    = '0;
    MemRdy      = 1'b0;
    fromMemData = '0;
  endtask

  task automatic rand_inputs();
    ChAddr      = {$urandom, $urandom};
    ChWrData    = {$urandom, $urandom};
    ChLength    = NCH'($urandom);
    ChRd        = NCH'($urandom);
    ChWr        = NCH'($urandom);
    ChEnable    = NCH'($urandom);
    MemRdy      = 1'($urandom);
    fromMemData = $urandom;
  endtask

  // Lets any access in flight complete, then leaves the arbiter idle.
  task automatic drain();
    ChEnable = '0;
    MemRdy   = 1'b1;
    repeat (3) step();
    MemRdy   = 1'b0;
  endtask

  logic [NCH-1:0] grants [4];
  logic [NCH-1:0] active;
  int             g;
  int             pulses;

  initial begin
    // Reset with random inputs
    Reset = 1'b1;
    rand_inputs();
    step();
    chk("reset ChGrant", 64'(ChGrant), 64'h0);
    chk("reset MemEnable", 64'(MemEnable), 64'h0);
    rand_inputs();
    step();
    chk("reset ChRdy", 64'(ChRdy), 64'h0);
    chk("reset MemAddr", 64'(MemAddr), 64'h0);
    idle_inputs();
    Reset = 1'b0;
    step();

    // ch1 read, two wait states
    ChAddr[AW +: AW] = 24'h000100;
    ChRd     = 2'b10;
    ChEnable = 2'b10;
    step();
    chk("rd t+1 MemEnable", 64'(MemEnable), 64'h1);
    chk("rd t+1 ChGrant", 64'(ChGrant), 64'h2);
    chk("rd t+1 MemAddr", 64'(MemAddr), 64'h100);
    step();
    chk("rd t+2 MemEnable", 64'(MemEnable), 64'h1);
    step();
    chk("rd t+3 MemEnable", 64'(MemEnable), 64'h1);
    chk("rd t+3 ChRdy", 64'(ChRdy), 64'h0);
    MemRdy      = 1'b1;
    fromMemData = 32'hDEADBEEF;
    step();
    chk("rd t+4 ChRdy", 64'(ChRdy), 64'h2);
    chk("rd t+4 ChRdData", 64'(ChRdData), 64'hDEADBEEF);
    chk("rd t+4 MemEnable", 64'(MemEnable), 64'h0);
    idle_inputs();
    step();
    chk("rd t+5 ChRdy", 64'(ChRdy), 64'h0);
    chk("rd held ChRdData", 64'(ChRdData), 64'hDEADBEEF);

    // Both channels held, back-to-back with zero wait states
    ChEnable = 2'b11;
    ChRd     = 2'b11;
    ChAddr   = {$urandom, $urandom};
    MemRdy   = 1'b1;
    for (int i = 0; i < 4; i++) grants[i] = '0;
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      step();
      if (ChGrant != '0) begin
        grants[g] = ChGrant;
        g++;
      end
    end
    drain();
`ifdef ARB_ROUND_ROBIN_EN
    chk("b2b grant0", 64'(grants[0]), 64'h1);
    chk("b2b grant1", 64'(grants[1]), 64'h2);
    chk("b2b grant2", 64'(grants[2]), 64'h1);
    chk("b2b grant3", 64'(grants[3]), 64'h2);
`else
    chk("b2b grant0", 64'(grants[0]), 64'h1);
    chk("b2b grant1", 64'(grants[1]), 64'h1);
    chk("b2b grant2", 64'(grants[2]), 64'h1);
    chk("b2b grant3", 64'(grants[3]), 64'h1);
`endif

    // Read and write both set on ch0: read wins
    idle_inputs();
    ChAddr[0 +: AW]   = 24'h00FFFC;
    ChWrData[0 +: DW] = 32'h12345678;
    ChRd     = 2'b01;
    ChWr     = 2'b01;
    ChEnable = 2'b01;
    step();
    chk("rw MemRd", 64'(MemRd), 64'h1);
    chk("rw MemWr", 64'(MemWr), 64'h0);
    chk("rw MemAddr", 64'(MemAddr), 64'h00FFFC);
    chk("rw toMemData", 64'(toMemData), 64'h12345678);
    fromMemData = $urandom;
    drain();

    // Reset while BUSY aborts the access
    idle_inputs();
    ChAddr[AW +: AW] = 24'($urandom);
    ChRd     = 2'b10;
    ChEnable = 2'b10;
    step();
    chk("abort busy MemEnable", 64'(MemEnable), 64'h1);
    Reset    = 1'b1;
    ChEnable = '0;
    step();
    chk("abort MemEnable", 64'(MemEnable), 64'h0);
    chk("abort ChRdy", 64'(ChRdy), 64'h0);
    chk("abort ChGrant", 64'(ChGrant), 64'h0);
    Reset    = 1'b0;
    ChRd     = 2'b11;
    ChEnable = 2'b11;
    step();
    chk("post-reset ChGrant", 64'(ChGrant), 64'h1);
    chk("post-reset ChRdy", 64'(ChRdy), 64'h0);
    drain();

    // ChEnable dropped right after grant
    idle_inputs();
    ChRd     = 2'b01;
    ChEnable = 2'b01;
    step();
    ChEnable = '0;
    step();
    MemRdy      = 1'b1;
    fromMemData = $urandom;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      MemRdy = 1'b0;
      if (ChRdy[0]) pulses++;
    end
    chk("drop ChRdy pulses", 64'(pulses), 64'h1);

    // Randomized traffic
    idle_inputs();
    active = '0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        Reset    = 1'b1;
        active   = '0;
        ChEnable = '0;
      end else begin
        Reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          if (active[i]) begin
            if (ChRdy[i]) begin
              active[i]   = 1'b0;
              ChEnable[i] = 1'b0;
            end else if (ChGrant[i] && $urandom_range(0, 3) == 0) begin
              ChEnable[i] = 1'b0;
            end
          end
          if (!active[i] && $urandom_range(0, 2) == 0) begin
            active[i]             = 1'b1;
            ChAddr[i*AW +: AW]    = 24'($urandom);
            ChWrData[i*DW +: DW]  = $urandom;
            ChLength[i]           = 1'($urandom);
            ChRd[i]               = 1'($urandom);
            ChWr[i]               = 1'($urandom);
            ChEnable[i]           = 1'b1;
          end
        end
      end
      MemRdy      = MemEnable ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      fromMemData = $urandom;
    end
    Reset = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
